pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the seven-stage pipeline (fetch1, fetch2, decode, execute, memory1, memory2, writeback). Detects load-use hazards between decode and the two stages behind it, freezes the whole pipe while the data cache is not ready, and flushes fetch on redirects. Drives `stall` / `stall_mem_wb` into `decode_pipe_unit` and the fetch/memory pipe registers. `decode_pipe_unit` builds its own bubble from these signals.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: data-cache wait cycles before `mem_timeout` sets; 8-bit counter.
- `PERF_WIDTH`, 32: width of the performance counters (only with the macro).

Ports (reset: `reset`, synchronous, active-high; clock: `clock`):
- `clock` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `rs1_decode`, `rs2_decode` in 5: source registers of the decode instruction.
- `uses_rs1_decode`, `uses_rs2_decode` in 1: the decode instruction reads that source.
- `rd_execute` in 5, `memRead_execute` in 1: destination register and load flag in execute.
- `rd_memory1` in 5, `memRead_memory1` in 1: destination register and load flag in memory1.
- `next_PC_select_execute` in 2, `branch_execute` in 1: redirect information.
- `d_mem_ready` in 1: data cache can accept or complete the memory1/memory2 access.
- `d_mem_busy` in 1: a memory access is present in memory1 or memory2.
- `stall` out 1: freeze fetch and decode pipe registers.
- `stall_mem_wb` out 1: freeze execute, memory and writeback registers (back-end stall).
- `flush_fetch` out 1: replace both fetch-stage instructions with NOP.
- `state` out 2: FSM state, for debug.
- `mem_timeout` out 1: sticky flag, set when the cache wait reaches its limit.

## Operation
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- **Redirect:** `redirect = (next_PC_select_execute==2'b1x) | (next_PC_select_execute==2'b01 & branch_execute)`.
- **Load-use hit:** `hit_ex` = `memRead_execute` & `rd_execute`≠0 & (`rd_execute` equals a used source of decode). `hit_m1` is the same test against memory1.
- **Load bypass:** load data is bypassed from writeback only. A hit in execute needs 2 stall cycles; a hit in memory1 needs 1.
- **MEM_WAIT condition:** `d_mem_busy & ~d_mem_ready`. This has the highest priority from any state.
  - `stall=1`, `stall_mem_wb=1`, `flush_fetch=0`.
  - The load counter is frozen.
  - When ready returns, go to LOAD_STALL if `ld_cnt`≠0, otherwise RUN.
- **Redirect in RUN or LOAD_STALL (not MEM_WAIT):**
  - `flush_fetch=1`, `stall=0`. `decode_pipe_unit` bubbles execute.
  - `ld_cnt` clears; next state is RUN.
  - Redirect takes priority over a load-use hit.
- **RUN, no redirect:**
  - If `hit_ex`: `stall=1` in the same cycle, `ld_cnt<=1`, go to LOAD_STALL.
  - Else if `hit_m1`: `stall=1` for that cycle only; stay in RUN.
- **LOAD_STALL:**
  - `stall=1`, `stall_mem_wb=0`.
  - `ld_cnt` decrements each cycle; leave for RUN when it reaches 0 after the decrement.
  - New hits are not re-evaluated while in LOAD_STALL.
- **Timeout counter `to_cnt`:**
  - Increments in MEM_WAIT and saturates at `MEM_TIMEOUT`.
  - `mem_timeout` sets when the count equals `MEM_TIMEOUT`.
  - The counter clears on leaving MEM_WAIT; the flag clears only on reset.
- **Stall outputs:** `stall` and `stall_mem_wb` are Mealy outputs (state plus current inputs). `state` is registered.

## Timing
- **Reset values:** `state`=RUN, `ld_cnt`=0, `to_cnt`=0, `mem_timeout`=0. `stall`=0, `stall_mem_wb`=0 and `flush_fetch`=0 unless an input condition asserts them.
- **Reset mid-operation:** on the next edge the block returns to RUN with all counters cleared.
- **Load in execute, dependent in decode:** `stall` is high for exactly 2 cycles; the dependent enters execute on the 3rd edge.
- **Redirect:** one cycle of `flush_fetch` per redirect cycle.
- **MEM_WAIT entry and exit:** both stall outputs are high in the same cycle ready drops. Exit is on the first cycle ready is high, and both are low in that cycle unless a load stall resumes.

## Configuration
- **`HAZARD_PERF_COUNTERS_EN` defined:**
  - Adds counters `perf_load_stalls`, `perf_mem_stalls` and `perf_flushes`, each `PERF_WIDTH` wide and reset to 0.
  - They count cycles with `stall` in RUN/LOAD_STALL, cycles in MEM_WAIT, and `flush_fetch` cycles respectively.
  - They wrap at 2^`PERF_WIDTH`, and the three ports are added.
- **Undefined:** no counters and no ports; core behaviour is identical.

## Structure
- **Shared pipeline package:** state encodings (RUN, LOAD_STALL, MEM_WAIT), `NOP`=32'h00000013, next_PC_select encodings (00 seq, 01 branch, 10 JAL, 11 JALR).
- **Sub-module `load_use_detect`:** combinational `hit_ex` / `hit_m1` comparison. The FSM, counters and perf counters stay in the top module.

## Test plan
- **Load-use from execute:** LW x5 in execute, decode reads x5 (`uses_rs1`) → `stall` high for 2 cycles, `state` 0→1→0.
- **Load-use from memory1:** LW x5 in memory1 only → `stall` high for 1 cycle, `state` stays 0. Same with rd=x0 → no stall.
- **Redirect during LOAD_STALL:** `next_PC_select_execute`=2'b10 in LOAD_STALL → `flush_fetch`=1, `stall`=0, next state RUN, `ld_cnt`=0.
- **Cache miss mid-stall:** `d_mem_ready`=0 with `d_mem_busy`=1 for 4 cycles during LOAD_STALL (`ld_cnt`=1) → both stalls high for 4 cycles, then 1 more `stall` cycle, then RUN.
- **Timeout:** with `MEM_TIMEOUT`=3, hold ready low for 5 cycles → `mem_timeout` sets after cycle 3 and stays set until `reset`.
- **Perf counters:** with `HAZARD_PERF_COUNTERS_EN`, the above sequence → counters match the stall and flush cycle counts. Assert `reset` mid-MEM_WAIT → all values return to 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM states, NOP, next-PC select codes.
// Used by pipeline_hazard_controller and its load-use detector.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_e;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JAL    = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    localparam int LD_CNT_W = 2;
    localparam int TO_CNT_W = 8;

    // x0 is never a real producer, so a load to it cannot create a hazard
    function automatic logic load_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        return mem_read && (rd != 5'd0) &&
               ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use comparison of the decode sources against
// the loads sitting in execute and memory1.
module load_use_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] rs1_decode,
    input  logic [4:0] rs2_decode,
    input  logic       uses_rs1_decode,
    input  logic       uses_rs2_decode,
    input  logic [4:0] rd_execute,
    input  logic       memRead_execute,
    input  logic [4:0] rd_memory1,
    input  logic       memRead_memory1,
    output logic       hit_ex,
    output logic       hit_m1
);

    assign hit_ex = load_hit(memRead_execute, rd_execute,
                             rs1_decode, rs2_decode,
                             uses_rs1_decode, uses_rs2_decode);

    assign hit_m1 = load_hit(memRead_memory1, rd_memory1,
                             rs1_decode, rs2_decode,
                             uses_rs1_decode, uses_rs2_decode);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the seven-stage pipe. Optional performance
// counters are enabled with the HAZARD_PERF_COUNTERS_EN macro.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned PERF_WIDTH  = 32
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] rs1_decode,
    input  logic [4:0] rs2_decode,
    input  logic       uses_rs1_decode,
    input  logic       uses_rs2_decode,
    input  logic [4:0] rd_execute,
    input  logic       memRead_execute,
    input  logic [4:0] rd_memory1,
    input  logic       memRead_memory1,
    input  logic [1:0] next_PC_select_execute,
    input  logic       branch_execute,
    input  logic       d_mem_ready,
    input  logic       d_mem_busy,
    output logic       stall,
    output logic       stall_mem_wb,
    output logic       flush_fetch,
    output logic [1:0] state,
    output logic       mem_timeout
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_load_stalls,
    output logic [PERF_WIDTH-1:0] perf_mem_stalls,
    output logic [PERF_WIDTH-1:0] perf_flushes
`endif
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(MEM_TIMEOUT);

    hz_state_e           state_q, state_d;
    logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    logic hit_ex;
    logic hit_m1;
    logic redirect;
    logic mem_wait;

    load_use_detect u_detect (
        .rs1_decode      (rs1_decode),
        .rs2_decode      (rs2_decode),
        .uses_rs1_decode (uses_rs1_decode),
        .uses_rs2_decode (uses_rs2_decode),
        .rd_execute      (rd_execute),
        .memRead_execute (memRead_execute),
        .rd_memory1      (rd_memory1),
        .memRead_memory1 (memRead_memory1),
        .hit_ex          (hit_ex),
        .hit_m1          (hit_m1)
    );

    assign redirect = next_PC_select_execute[1] |
                      ((next_PC_select_execute == NPC_BRANCH) & branch_execute);
    assign mem_wait = d_mem_busy & ~d_mem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            ld_cnt_q      <= '0;
            to_cnt_q      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Cache wait overrides everything and holds the load counter
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        if (mem_wait) begin
            state_d = MEM_WAIT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect) begin
                        ld_cnt_d = '0;
                    end else if (hit_ex) begin
                        ld_cnt_d = LD_CNT_W'(1);
                        state_d  = LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    if (redirect) begin
                        ld_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        if (ld_cnt_q != '0) begin
                            ld_cnt_d = ld_cnt_q - LD_CNT_W'(1);
                        end
                        state_d = (ld_cnt_d == '0) ? RUN : LOAD_STALL;
                    end
                end
                MEM_WAIT: begin
                    if (ld_cnt_q != '0) begin
                        state_d = LOAD_STALL;
                    end else if (hit_ex) begin
                        ld_cnt_d = LD_CNT_W'(1);
                        state_d  = LOAD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    ld_cnt_d = '0;
                    state_d  = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall        = 1'b0;
        stall_mem_wb = 1'b0;
        flush_fetch  = 1'b0;
        if (mem_wait) begin
            stall        = 1'b1;
            stall_mem_wb = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect) begin
                        flush_fetch = 1'b1;
                    end else if (hit_ex | hit_m1) begin
                        stall = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    if (redirect) begin
                        flush_fetch = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    stall = (ld_cnt_q == '0) & (hit_ex | hit_m1);
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        to_cnt_d = '0;
        if (mem_wait) begin
            to_cnt_d = (to_cnt_q >= TO_LIMIT) ? to_cnt_q
                                              : to_cnt_q + TO_CNT_W'(1);
        end
        mem_timeout_d = mem_timeout_q | (mem_wait & (to_cnt_d == TO_LIMIT));
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [PERF_WIDTH-1:0] perf_load_q, perf_load_d;
    logic [PERF_WIDTH-1:0] perf_mem_q, perf_mem_d;
    logic [PERF_WIDTH-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_load_d  = perf_load_q + PERF_WIDTH'(stall & ~mem_wait);
        perf_mem_d   = perf_mem_q + PERF_WIDTH'(mem_wait);
        perf_flush_d = perf_flush_q + PERF_WIDTH'(flush_fetch);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_load_q  <= '0;
            perf_mem_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_load_q  <= perf_load_d;
            perf_mem_q   <= perf_mem_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_load_stalls = perf_load_q;
    assign perf_mem_stalls  = perf_mem_q;
    assign perf_flushes     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector bench for pipeline_hazard_controller (MEM_TIMEOUT=3).
// Each record drives one cycle and checks the outputs seen in that cycle.
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] rs1_decode, rs2_decode;
    logic       uses_rs1_decode, uses_rs2_decode;
    logic [4:0] rd_execute, rd_memory1;
    logic       memRead_execute, memRead_memory1;
    logic [1:0] next_PC_select_execute;
    logic       branch_execute;
    logic       d_mem_ready, d_mem_busy;
    logic       stall, stall_mem_wb, flush_fetch;
    logic [1:0] state;
    logic       mem_timeout;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_load_stalls, perf_mem_stalls, perf_flushes;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(.MEM_TIMEOUT(3), .PERF_WIDTH(32)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .rs1_decode             (rs1_decode),
        .rs2_decode             (rs2_decode),
        .uses_rs1_decode        (uses_rs1_decode),
        .uses_rs2_decode        (uses_rs2_decode),
        .rd_execute             (rd_execute),
        .memRead_execute        (memRead_execute),
        .rd_memory1             (rd_memory1),
        .memRead_memory1        (memRead_memory1),
        .next_PC_select_execute (next_PC_select_execute),
        .branch_execute         (branch_execute),
        .d_mem_ready            (d_mem_ready),
        .d_mem_busy             (d_mem_busy),
        .stall                  (stall),
        .stall_mem_wb           (stall_mem_wb),
        .flush_fetch            (flush_fetch),
        .state                  (state),
        .mem_timeout            (mem_timeout)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .perf_load_stalls       (perf_load_stalls),
        .perf_mem_stalls        (perf_mem_stalls),
        .perf_flushes           (perf_flushes)
`endif
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rdex;
        logic       mrex;
        logic [4:0] rdm1;
        logic       mrm1;
        logic [1:0] nps;
        logic       br;
        logic       rdy;
        logic       busy;
        logic       e_stall;
        logic       e_smwb;
        logic       e_flush;
        logic [1:0] e_state;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rst,
        input logic [4:0] rs1, input logic u1,
        input logic [4:0] rs2, input logic u2,
        input logic [4:0] rdex, input logic mrex,
        input logic [4:0] rdm1, input logic mrm1,
        input logic [1:0] nps, input logic br,
        input logic rdy, input logic busy,
        input logic es, input logic ew, input logic ef,
        input logic [1:0] est, input logic eto
    );
        vec_t v;
        v = '{rst, rs1, u1, rs2, u2, rdex, mrex, rdm1, mrm1,
              nps, br, rdy, busy, es, ew, ef, est, eto};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset                  = v.rst;
        rs1_decode             = v.rs1;
        uses_rs1_decode        = v.u1;
        rs2_decode             = v.rs2;
        uses_rs2_decode        = v.u2;
        rd_execute             = v.rdex;
        memRead_execute        = v.mrex;
        rd_memory1             = v.rdm1;
        memRead_memory1        = v.mrm1;
        next_PC_select_execute = v.nps;
        branch_execute         = v.br;
        d_mem_ready            = v.rdy;
        d_mem_busy             = v.busy;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk("stall", idx, 32'(stall), 32'(v.e_stall));
        chk("stall_mem_wb", idx, 32'(stall_mem_wb), 32'(v.e_smwb));
        chk("flush_fetch", idx, 32'(flush_fetch), 32'(v.e_flush));
        chk("state", idx, 32'(state), 32'(v.e_state));
        chk("mem_timeout", idx, 32'(mem_timeout), 32'(v.e_to));
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        // rst rs1 u1 rs2 u2 rdex mrex rdm1 mrm1 nps br rdy busy | stall smwb flush state to
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 0 reset state
        add(0, 5,1, 0,0, 5,1, 0,0, 0,0, 1,0,  1,0,0,0,0); // 1 hit_ex
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 1,0,  1,0,0,1,0); // 2 LOAD_STALL
        add(0, 5,1, 0,0, 5,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 3 back to RUN
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 1,0,  1,0,0,0,0); // 4 hit_m1
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 5 stays RUN
        add(0, 0,1, 0,0, 0,0, 0,1, 0,0, 1,0,  0,0,0,0,0); // 6 rd=x0
        add(0, 0,0, 7,0, 7,1, 0,0, 0,0, 1,0,  0,0,0,0,0); // 7 rs2 unused
        add(0, 0,0, 7,1, 7,1, 0,0, 0,0, 1,0,  1,0,0,0,0); // 8 rs2 hit_ex
        add(0, 0,0, 7,1, 0,0, 7,1, 2,0, 1,0,  0,0,1,1,0); // 9 JAL in LOAD_STALL
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 10
        add(0, 3,1, 0,0, 3,1, 0,0, 1,1, 1,0,  0,0,1,0,0); // 11 taken branch beats hit
        add(0, 0,0, 0,0, 0,0, 0,0, 1,0, 1,0,  0,0,0,0,0); // 12 not-taken branch
        add(0, 0,0, 0,0, 0,0, 0,0, 3,0, 1,0,  0,0,1,0,0); // 13 JALR
        add(0, 5,1, 0,0, 5,1, 0,0, 0,0, 1,0,  1,0,0,0,0); // 14 hit_ex
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 0,1,  1,1,0,1,0); // 15 miss in LOAD_STALL
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 0,1,  1,1,0,2,0); // 16
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 0,1,  1,1,0,2,0); // 17
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 0,1,  1,1,0,2,1); // 18 timeout set
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 1,1,  0,0,0,2,1); // 19 ready returns
        add(0, 5,1, 0,0, 0,0, 5,1, 0,0, 1,1,  1,0,0,1,1); // 20 resumed stall
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,1); // 21
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0,1); // 22 not busy
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,0,1); // 23 miss from RUN
        add(0, 0,0, 0,0, 0,0, 0,0, 2,0, 0,1,  1,1,0,2,1); // 24 no flush in wait
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,2,1); // 25 exit
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,1); // 26
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,0,1); // 27
        add(1, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,2,1); // 28 reset in MEM_WAIT
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 29 cleared
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,0,0); // 30 timeout run
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,2,0); // 31
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,2,0); // 32
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,2,1); // 33 set after 3
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,2,1); // 34
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,2,1); // 35
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,1); // 36 sticky
        add(1, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,1); // 37 reset
        add(0, 0,0, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,0,0); // 38

        idle = vecs[0];
        idle.rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
`ifdef HAZARD_PERF_COUNTERS_EN
            if (i == 28) begin
                chk("perf_load_stalls", i, perf_load_stalls, 32'd6);
                chk("perf_mem_stalls", i, perf_mem_stalls, 32'd7);
                chk("perf_flushes", i, perf_flushes, 32'd3);
            end
            if (i == 29) begin
                chk("perf_load_rst", i, perf_load_stalls, 32'd0);
                chk("perf_mem_rst", i, perf_mem_stalls, 32'd0);
                chk("perf_flush_rst", i, perf_flushes, 32'd0);
            end
`endif
            drive(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end

        // Reset in the middle of a load stall
        @(negedge clock);
        v = vecs[1];
        drive(v);
        #1;
        chk("seq_hit_stall", 100, 32'(stall), 32'd1);
        @(negedge clock);
        chk("seq_in_ls", 101, 32'(state), 32'd1);
        v = vecs[0];
        v.rst = 1'b1;
        drive(v);
        @(negedge clock);
        chk("seq_rst_state", 102, 32'(state), 32'd0);
        drive(vecs[0]);
        #1;
        chk("seq_rst_stall", 103, 32'(stall), 32'd0);
        @(negedge clock);
        chk("seq_still_run", 104, 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
